// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts WIDTH-bit words over valid/ready and streams them one bit per clk.
// Optional macro PARITY_EN appends an even-parity bit after every word.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef PARITY_EN
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count_reg;
`ifdef PARITY_EN
    logic             parity_reg;
`endif

    // The shifter always works MSB-first; LSB-first order is handled by reversing the word on entry.
    logic [WIDTH-1:0] ordered_data;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
        assign ordered_data[gi] = MSB_FIRST ? load_data[gi] : load_data[WIDTH-1-gi];
    end

    logic take;
    assign take = load_valid & load_ready;

    always_comb begin
        load_ready = 1'b0;
        if (rst) begin
            case (state_reg)
                IDLE:    load_ready = 1'b1;
`ifdef PARITY_EN
                PARITY:  load_ready = 1'b1;
`else
                SHIFT:   load_ready = (count_reg == LAST);
`endif
                default: load_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            count_reg  <= '0;
`ifdef PARITY_EN
            parity_reg <= 1'b0;
`endif
            ser_out    <= IDLE_BIT;
            ser_valid  <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else if (take) begin
            // Any accepted word starts immediately, which gives gapless back-to-back streaming.
            state_reg  <= SHIFT;
            count_reg  <= '0;
            shift_reg  <= ordered_data << 1;
            ser_out    <= ordered_data[WIDTH-1];
            ser_valid  <= 1'b1;
            busy       <= 1'b1;
            word_done  <= 1'b0;
`ifdef PARITY_EN
            parity_reg <= ^load_data;
`endif
        end else begin
            word_done <= 1'b0;
            case (state_reg)
                SHIFT: begin
                    if (count_reg != LAST) begin
                        count_reg <= count_reg + 1'b1;
                        shift_reg <= shift_reg << 1;
                        ser_out   <= shift_reg[WIDTH-1];
`ifndef PARITY_EN
                        word_done <= (count_reg == PENULT);
`endif
                    end else begin
`ifdef PARITY_EN
                        state_reg <= PARITY;
                        ser_out   <= parity_reg;
                        word_done <= 1'b1;
`else
                        state_reg <= IDLE;
                        count_reg <= '0;
                        shift_reg <= '0;
                        ser_out   <= IDLE_BIT;
                        ser_valid <= 1'b0;
                        busy      <= 1'b0;
`endif
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    shift_reg <= '0;
                    ser_out   <= IDLE_BIT;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed, table-driven bench for serial_bit_feeder (MSB-first and LSB-first instances).
module tb_serial_bit_feeder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ld, ld2;
    logic       lv, lv2;
    logic       ready, so, sv, wd, bsy;
    logic       ready2, so2, sv2, wd2, bsy2;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .load_data(ld), .load_valid(lv), .load_ready(ready),
        .ser_out(so), .ser_valid(sv), .word_done(wd), .busy(bsy)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_data(ld2), .load_valid(lv2), .load_ready(ready2),
        .ser_out(so2), .ser_valid(sv2), .word_done(wd2), .busy(bsy2)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       eso, esv, ewd, erdy, ebsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic eso, input logic esv,
                       input logic ewd, input logic erdy, input logic ebsy);
        vec_t e;
        e.valid = v; e.data = d;
        e.eso = eso; e.esv = esv; e.ewd = ewd; e.erdy = erdy; e.ebsy = ebsy;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic eso, input logic esv, input logic ewd,
                            input logic erdy, input logic ebsy);
        $display("%s: ser_out=%b ser_valid=%b word_done=%b load_ready=%b busy=%b",
                 tag, so, sv, wd, ready, bsy);
        chk($sformatf("%s ser_out", tag), so, eso);
        chk($sformatf("%s ser_valid", tag), sv, esv);
        chk($sformatf("%s word_done", tag), wd, ewd);
        chk($sformatf("%s load_ready", tag), ready, erdy);
        chk($sformatf("%s busy", tag), bsy, ebsy);
    endtask

    task automatic chk_lsb(input string tag, input logic eso, input logic esv, input logic ewd,
                           input logic erdy, input logic ebsy);
        $display("%s: ser_out=%b ser_valid=%b word_done=%b load_ready=%b busy=%b",
                 tag, so2, sv2, wd2, ready2, bsy2);
        chk($sformatf("%s ser_out", tag), so2, eso);
        chk($sformatf("%s ser_valid", tag), sv2, esv);
        chk($sformatf("%s word_done", tag), wd2, ewd);
        chk($sformatf("%s load_ready", tag), ready2, erdy);
        chk($sformatf("%s busy", tag), bsy2, ebsy);
    endtask

    initial begin
`ifdef PARITY_EN
        logic [17:0] sp;
`else
        logic [7:0]  sa;
        logic [15:0] sb;
        logic [15:0] sc;
        logic [7:0]  sl;
        logic [7:0]  sr;
`endif

`ifdef PARITY_EN
        // D8 -> 11011000 + parity 0, C1 -> 11000001 + parity 1, back to back.
        sp = 18'b110110000110000011;
        add(1'b1, 8'hD8, sp[17], 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 17; k++)
            add(k <= 9, (k <= 9) ? 8'hC1 : 8'h00, sp[17-k], 1'b1,
                (k == 8) || (k == 17), (k == 8) || (k == 17), 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        // Single word D8, MSB first.
        sa = 8'b11011000;
        add(1'b1, 8'hD8, sa[7], 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++)
            add(1'b0, 8'h00, sa[7-k], 1'b1, k == 7, k == 7, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Back to back C0 then 18 with valid held high.
        sb = 16'b1100000000011000;
        add(1'b1, 8'hC0, sb[15], 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 15; k++)
            add(k <= 8, (k <= 8) ? 8'h18 : 8'h00, sb[15-k], 1'b1,
                (k == 7) || (k == 15), (k == 7) || (k == 15), 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Backpressure: next word 3C offered while 3 bits of E4 remain.
        sc = 16'b1110010000111100;
        add(1'b1, 8'hE4, sc[15], 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 15; k++)
            add((k >= 5) && (k <= 8), ((k >= 5) && (k <= 8)) ? 8'h3C : 8'h00, sc[15-k], 1'b1,
                (k == 7) || (k == 15), (k == 7) || (k == 15), 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        rst = 1'b0; lv = 1'b0; ld = 8'h00; lv2 = 1'b0; ld2 = 8'h00;
        #12;
        chk_main("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("idle load_ready", ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            lv = vecs[i].valid;
            ld = vecs[i].data;
            @(posedge clk);
            #1;
            chk_main($sformatf("vec%0d valid=%b data=%h", i, vecs[i].valid, vecs[i].data),
                     vecs[i].eso, vecs[i].esv, vecs[i].ewd, vecs[i].erdy, vecs[i].ebsy);
        end
        lv = 1'b0;

`ifndef PARITY_EN
        // LSB-first instance, word 1B -> 1,1,0,1,1,0,0,0.
        sl = 8'b11011000;
        lv2 = 1'b1; ld2 = 8'h1B;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            #1;
            lv2 = 1'b0;
            chk_lsb($sformatf("lsb bit%0d", k), sl[7-k], 1'b1, k == 7, k == 7, 1'b1);
        end
        @(posedge clk);
        #1;
        chk_lsb("lsb idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of word FF, then a clean 0F.
        lv = 1'b1; ld = 8'hFF;
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk);
            #1;
            lv = 1'b0;
            chk_main($sformatf("ff bit%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        #2 rst = 1'b0;
        #1;
        chk_main("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        sr = 8'b00001111;
        lv = 1'b1; ld = 8'h0F;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            #1;
            lv = 1'b0;
            chk_main($sformatf("0f bit%0d", k), sr[7-k], 1'b1, k == 7, k == 7, 1'b1);
        end
        @(posedge clk);
        #1;
        chk_main("0f idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Parallel-to-serial front end for the Moore sequence detectors, such as the 11000 overlapping detector. It accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clk on ser_out. Back-to-back words stream with no gap, so downstream detectors see a continuous bit stream. ser_out connects directly to a detector's single-bit serial input.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first
IDLE_BIT, 0, value driven on ser_out when no word is being shifted

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
load_data  input  WIDTH  word to serialise
load_valid  input  1  load_data valid
load_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial bit to the detector, registered
ser_valid  output  1  ser_out carries a data (or parity) bit, registered
word_done  output  1  one-cycle pulse, high while the final bit of a word is on ser_out
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0.
  - load_ready forced 0 while rst=0.
- Handshake:
  - A transfer occurs on a rising edge with load_valid=1 and load_ready=1.
  - load_data is captured on that edge.
  - Nothing is captured when load_ready=0. The source must hold the word.
- load_ready (combinational from state/counter):
  - 1 in IDLE.
  - 1 in SHIFT when counter==WIDTH-1 and PARITY_EN is not defined.
  - 1 in PARITY when PARITY_EN is defined.
  - 0 otherwise.
- States: IDLE, SHIFT, PARITY (PARITY exists only with PARITY_EN).
  - IDLE -> SHIFT on a transfer.
  - SHIFT holds while counter<WIDTH-1.
  - At counter==WIDTH-1:
    - with PARITY_EN: -> PARITY.
    - without PARITY_EN: transfer -> stay in SHIFT (new word, counter=0); no transfer -> IDLE.
  - PARITY: transfer -> SHIFT (counter=0); no transfer -> IDLE.
- Latency: a word accepted at edge N drives its first bit on ser_out after edge N, with ser_valid=1. Bit k appears after edge N+k.
- Bit order:
  - MSB_FIRST=1: load_data[WIDTH-1] first, down to [0].
  - MSB_FIRST=0: [0] first, up to [WIDTH-1].
- word_done is 1 in the same cycle the last data bit is on ser_out (or the parity bit, with PARITY_EN). Otherwise 0.
- Back-to-back words: no idle cycle inserted. The first bit of word 2 directly follows the last bit of word 1, and ser_valid stays 1.
- Returning to IDLE: after the last bit, ser_out=IDLE_BIT and ser_valid=0 from the next edge.
- Counter: width $clog2(WIDTH); it never exceeds WIDTH-1.
- Reset mid-word: the word is dropped immediately and outputs take their reset values. After rst deasserts, the first transfer starts a fresh word from bit 0.
- load_valid while busy and not ready: ignored; the output stream is unaffected.

Optional Feature:
Macro PARITY_EN.
- Defined: after the WIDTH data bits, one even-parity bit (XOR of the captured word) is shifted out in state PARITY, with ser_valid=1. word_done is asserted on the parity bit, not the last data bit. A word occupies WIDTH+1 cycles, and load_ready is high only in PARITY.
- Not defined: no PARITY state. A word occupies WIDTH cycles, and load_ready follows the SHIFT rule above.

Test Plan:
- Reset then single word, WIDTH=8, MSB_FIRST=1, load 8'hD8 at edge N: ser_out=1,1,0,1,1,0,0,0 after edges N..N+7, with ser_valid=1. word_done=1 only on the final 0. Then ser_out=IDLE_BIT, ser_valid=0, busy=0.
- Back-to-back, no PARITY_EN: 8'hC0 then 8'h18, load_valid held high: 16 contiguous bits 1100000000011000. ser_valid never drops, load_ready pulses once mid-stream, word_done pulses twice 8 cycles apart. A downstream 11000 detector sees the 11000 patterns at bits 0-4 and 11-15 of the stream.
- LSB order, MSB_FIRST=0, load 8'h1B: ser_out=1,1,0,1,1,0,0,0.
- Backpressure: load_valid=1 with a new word while 3 bits remain: load_ready=0 for those cycles. The current word completes intact and the new word starts exactly after its last bit.
- Reset mid-word: assert rst=0 asynchronously after 4 bits of 8'hFF: outputs immediately reset (ser_valid=0, busy=0). Release and load 8'h0F: the full 0,0,0,0,1,1,1,1 stream appears with no residue.
- PARITY_EN: 8'hD8 -> 8 data bits then parity 0; 8'hC1 -> data bits then parity 1. word_done is on the parity bit, and each word spans 9 cycles back-to-back.
